// File: rtl/bram_stream_pkg.sv
// Shared defaults for the block RAM and its read-side streamer, plus the
// streamer's state encoding.
package bram_stream_pkg;

   localparam int BRAM_ADDR_WIDTH = 16;
   localparam int BRAM_DATA_WIDTH = 128;
   localparam int BRAM_MEM_DEPTH  = 'h4000;
   localparam int BRAM_LEN_WIDTH  = 17;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      FLUSH,
      DONE
   } rd_state_e;

endpackage

// File: rtl/bram_pdp.sv
// Pseudo-dual-port block RAM: one write port and one registered read port.
// The lock input freezes rddata so a stalled consumer can keep using it.
module bram_pdp
   import bram_stream_pkg::*;
#(
   parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
   parameter int MEM_DEPTH  = BRAM_MEM_DEPTH
) (
   input  logic                  clk,
   input  logic                  wren,
   input  logic [ADDR_WIDTH-1:0] wraddr,
   input  logic [DATA_WIDTH-1:0] wrdata,
   input  logic                  rden,
   input  logic [ADDR_WIDTH-1:0] rdaddr,
   input  logic                  lock,
   output logic [DATA_WIDTH-1:0] rddata
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // Address bits above the array index are never used by the storage.
   if (IDX_W < ADDR_WIDTH) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^{wraddr[ADDR_WIDTH-1:IDX_W], rdaddr[ADDR_WIDTH-1:IDX_W]};
   end

   always_ff @(posedge clk) begin
      if (wren) begin
         mem[wraddr[IDX_W-1:0]] <= wrdata;
      end
      if (rden & ~lock) begin
         rddata <= mem[rdaddr[IDX_W-1:0]];
      end
   end

endmodule

// File: rtl/bram_rd_streamer.sv
// Turns a (base, length) command into sequential BRAM reads presented as an
// AXI4-Stream master; backpressure freezes the BRAM output via lock.
module bram_rd_streamer
   import bram_stream_pkg::*;
#(
   parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
   parameter int MEM_DEPTH  = BRAM_MEM_DEPTH,
   parameter int LEN_WIDTH  = BRAM_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  bram_rden,
   output logic [ADDR_WIDTH-1:0] bram_rdaddr,
   output logic                  bram_lock,
   input  logic [DATA_WIDTH-1:0] bram_rddata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [LEN_WIDTH-1:0]  DEPTH_LEN = LEN_WIDTH'(MEM_DEPTH);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

   rd_state_e             state;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [LEN_WIDTH-1:0]  issue_cnt;
   logic [LEN_WIDTH-1:0]  beat_cnt;
   logic                  dv;
   logic                  tlast_r;
   logic                  last_issue;
   logic                  beat_fire;

   function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
   endfunction

   // Handshake: a beat transfers on any clock edge where m_axis_tvalid and
   // m_axis_tready are both high; while tvalid is high and tready low the BRAM
   // output is locked, so tdata/tlast stay constant until the beat transfers.
   assign bram_lock     = dv & ~m_axis_tready;
   assign bram_rden     = (state == READ) & ~bram_lock & (len_r != '0);
   assign bram_rdaddr   = rd_addr;
   assign m_axis_tvalid = dv;
   assign m_axis_tdata  = bram_rddata;
   assign m_axis_tlast  = tlast_r;
   assign cmd_ready     = (state == IDLE);
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);

   assign last_issue = ((issue_cnt + LEN_ONE) == len_r);
   assign beat_fire  = dv & m_axis_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_addr   <= '0;
         len_r     <= '0;
         issue_cnt <= '0;
         beat_cnt  <= '0;
         dv        <= 1'b0;
         tlast_r   <= 1'b0;
      end else begin
         dv <= bram_rden | bram_lock;
         if (bram_rden) begin
            tlast_r <= last_issue;
         end else if (!bram_lock) begin
            tlast_r <= 1'b0;
         end
         if (beat_fire) begin
            beat_cnt <= beat_cnt + LEN_ONE;
         end

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  rd_addr   <= cmd_addr;
                  len_r     <= cmd_len;
                  issue_cnt <= '0;
                  beat_cnt  <= '0;
                  state     <= READ;
               end
            end
            READ: begin
               // Zero-length commands pass through READ without issuing, so
               // done keeps the same two-cycle offset as the first beat.
               if (len_r == '0) begin
                  state <= DONE;
               end else if (bram_rden) begin
                  rd_addr   <= addr_inc(rd_addr);
                  issue_cnt <= issue_cnt + LEN_ONE;
                  if (last_issue) begin
                     state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (beat_fire & tlast_r) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   a_len_range : assert property (@(posedge clk) disable iff (rst)
      (cmd_valid && cmd_ready) |-> (cmd_len <= DEPTH_LEN));

   a_tlast_count : assert property (@(posedge clk) disable iff (rst)
      (beat_fire && tlast_r) |-> (beat_cnt == (len_r - LEN_ONE)));

   a_stall_hold : assert property (@(posedge clk) disable iff (rst)
      (dv && !m_axis_tready) |=> (dv && $stable(tlast_r)));

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Bench for bram_rd_streamer driving a real bram_pdp preloaded with mem[i]=i.
module tb_bram_rd_streamer;
   import bram_stream_pkg::*;

   localparam int AW    = 16;
   localparam int DW    = 128;
   localparam int DEPTH = 'h4000;
   localparam int LW    = 17;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          bram_rden;
   logic [AW-1:0] bram_rdaddr;
   logic          bram_lock;
   logic [DW-1:0] bram_rddata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic          busy;
   logic          done;
   logic          wren = 1'b0;
   logic [AW-1:0] wraddr = '0;
   logic [DW-1:0] wrdata = '0;

   bram_rd_streamer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .bram_rden(bram_rden), .bram_rdaddr(bram_rdaddr),
      .bram_lock(bram_lock), .bram_rddata(bram_rddata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .done(done)
   );

   bram_pdp #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)
   ) u_bram (
      .clk(clk), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
      .rden(bram_rden), .rdaddr(bram_rdaddr), .lock(bram_lock),
      .rddata(bram_rddata)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state: {tlast, tdata}
   logic [DW:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int ready_mode = 0;
   int hs_edge, first_acc, last_acc, done_edge;
   int done_cnt = 0;
   int beat_seen = 0;

   typedef struct {
      int addr;
      int len;
      int mode;       // 0 ready, 1 pattern 1,0,0,1, 2 random
      int exp_first;  // first-beat edges after handshake, -1 = not checked
      int exp_beats;
   } cmd_vec_t;

   cmd_vec_t vecs[6];

   task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic monitor_loop();
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic          prev_last;
      logic [DW:0]   e;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            chk("lock_on_stall", bram_lock, m_axis_tvalid & ~m_axis_tready);
            if (m_axis_tvalid & ~m_axis_tready) chk("rden_in_stall", bram_rden, 0);
            if (prev_stall) begin
               chk("stall_tvalid", m_axis_tvalid, 1);
               chk("stall_tdata", m_axis_tdata, prev_data);
               chk("stall_tlast", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid & m_axis_tready) begin
               beat_seen++;
               if (first_acc < 0) first_acc = cyc + 1;
               last_acc = cyc + 1;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", {m_axis_tlast, m_axis_tdata}, e);
               end
            end
            if (done) begin
               done_edge = cyc + 1;
               done_cnt++;
            end
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
         end
      end
   endtask

   task automatic ready_driver();
      logic [3:0] pat;
      int pidx;
      pat  = 4'b1001;
      pidx = 0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: m_axis_tready = 1'b1;
            1: begin
               m_axis_tready = pat[pidx];
               pidx = (pidx + 1) % 4;
            end
            2: m_axis_tready = 1'($urandom_range(0, 1));
            default: ;
         endcase
      end
   endtask

   task automatic push_expected(input int addr, input int len);
      for (int i = 0; i < len; i++) begin
         exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, DW'((addr + i) % DEPTH)});
      end
   endtask

   task automatic start_cmd(input int addr, input int len);
      first_acc = -1;
      done_edge = -1;
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_addr  = AW'(addr);
      cmd_len   = LW'(len);
      tick(1);
      hs_edge   = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd(input int len, input int exp_beats, input int b0, input int d0);
      int bound;
      bound = len * 8 + 50;
      while (done_edge < 0 && bound > 0) begin
         tick(1);
         bound--;
      end
      if (done_edge < 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done required=done len=%0d", len);
         exp_q.delete();
      end else begin
         if (len == 0) chk("done_lat_len0", done_edge - hs_edge, 2);
         else          chk("done_after_last", done_edge - last_acc, 1);
         chk("beat_count", beat_seen - b0, exp_beats);
         chk("queue_empty", exp_q.size(), 0);
         tick(1);
         chk("done_pulse_count", done_cnt - d0, 1);
         chk("cmd_ready_back", cmd_ready, 1);
         chk("busy_clear", busy, 0);
      end
   endtask

   task automatic run_cmd(input cmd_vec_t v);
      int b0;
      int d0;
      ready_mode = v.mode;
      push_expected(v.addr, v.len);
      b0 = beat_seen;
      d0 = done_cnt;
      start_cmd(v.addr, v.len);
      finish_cmd(v.len, v.exp_beats, b0, d0);
      if (v.exp_first >= 0) chk("first_beat_lat", first_acc - hs_edge, v.exp_first);
   endtask

   initial begin
      int b0;
      int d0;
      int bound;
      cmd_vec_t v;

      vecs[0] = '{addr: 'h10,  len: 4,  mode: 0, exp_first: 2,  exp_beats: 4};
      vecs[1] = '{addr: 'h20,  len: 8,  mode: 1, exp_first: -1, exp_beats: 8};
      vecs[2] = '{addr: 16382, len: 4,  mode: 0, exp_first: 2,  exp_beats: 4};
      vecs[3] = '{addr: 'h30,  len: 0,  mode: 0, exp_first: -1, exp_beats: 0};
      vecs[4] = '{addr: 'h100, len: 20, mode: 2, exp_first: -1, exp_beats: 20};
      vecs[5] = '{addr: 'h3ff, len: 1,  mode: 0, exp_first: 2,  exp_beats: 1};

      fork
         monitor_loop();
         ready_driver();
      join_none

      // preload mem[i] = i while the streamer is held in reset
      tick(1);
      for (int i = 0; i < DEPTH; i++) begin
         wren   = 1'b1;
         wraddr = AW'(i);
         wrdata = DW'(i);
         tick(1);
      end
      wren = 1'b0;

      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_rden", bram_rden, 0);
      chk("rst_lock", bram_lock, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(2);

      for (int k = 0; k < 6; k++) begin
         v = vecs[k];
         run_cmd(v);
         tick(1);
      end

      // single beat held 5 cycles under backpressure
      ready_mode = 3;
      tick(1);
      m_axis_tready = 1'b0;
      push_expected('h40, 1);
      b0 = beat_seen;
      d0 = done_cnt;
      start_cmd('h40, 1);
      bound = 10;
      while (!m_axis_tvalid && bound > 0) begin
         tick(1);
         bound--;
      end
      for (int k = 0; k < 5; k++) begin
         chk("hold_tvalid", m_axis_tvalid, 1);
         chk("hold_tlast", m_axis_tlast, 1);
         chk("hold_tdata", m_axis_tdata, DW'('h40));
         chk("hold_lock", bram_lock, 1);
         tick(1);
      end
      m_axis_tready = 1'b1;
      finish_cmd(1, 1, b0, d0);
      ready_mode = 0;
      tick(1);

      // reset in the middle of a 16-beat transfer
      push_expected('h200, 16);
      start_cmd('h200, 16);
      tick(8);
      rst = 1'b1;
      tick(1);
      chk("midrst_tvalid", m_axis_tvalid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      rst = 1'b0;
      exp_q.delete();
      tick(2);
      v = '{addr: 0, len: 2, mode: 0, exp_first: 2, exp_beats: 2};
      run_cmd(v);
      tick(1);

      // whole memory once, starting off zero so it wraps
      v = '{addr: 5, len: DEPTH, mode: 0, exp_first: 2, exp_beats: DEPTH};
      run_cmd(v);
      tick(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
